hl_south_io_ctrl: RTL

//  Core-side controller for the 8-slice south IO bank. Drives every per-slice pad control (dq, enq, enabq, drv*, pull, slew, pwrup*) and sequences pad power-up/down.

---
 rtl/hl_io_pkg.sv | 32 +++
 rtl/hl_io_in_filter.sv | 70 +++++++
 rtl/hl_south_io_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hl_io_pkg.sv
// rtl/hl_io_pkg.sv - Shared types and config field layout for the south IO bank controller
package hl_io_pkg;

  typedef enum logic [1:0] {
    HIZ    = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2
  } io_state_e;

  localparam int CFG_W        = 8;
  localparam int CFG_DRV_LSB  = 0;
  localparam int CFG_SLEW     = 3;
  localparam int CFG_PULL_LSB = 4;
  localparam int CFG_PPEN     = 6;
  localparam int CFG_IE       = 7;

  localparam logic [1:0] PULL_NONE     = 2'b00;
  localparam logic [1:0] PULL_UP       = 2'b01;
  localparam logic [1:0] PULL_DOWN     = 2'b10;
  localparam logic [1:0] PULL_NONE_ALT = 2'b11;

  // Returns {puq, pd}; the pull-up and pull-down are never enabled together.
  function automatic logic [1:0] pull_decode(input logic [1:0] pull);
    case (pull)
      PULL_UP:                  return 2'b00;
      PULL_DOWN:                return 2'b11;
      PULL_NONE, PULL_NONE_ALT: return 2'b10;
      default:                  return 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/hl_io_in_filter.sv
// rtl/hl_io_in_filter.sv - One pad input: 2-flop synchronizer, run-length glitch filter, edge pulses
module hl_io_in_filter #(
  parameter int FILT_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pad_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
    end
  end

  if (FILT_CYCLES == 0) begin : g_bypass
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        filt_o <= 1'b0;
        rise_o <= 1'b0;
        fall_o <= 1'b0;
      end else begin
        filt_o <= sync2_q;
        rise_o <= sync2_q & ~filt_o;
        fall_o <= ~sync2_q & filt_o;
      end
    end
  end else begin : g_filter
    localparam int RUN_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_CYCLES - 1);

    logic             samp_q;
    logic [RUN_W-1:0] run_q;

    // run_q counts consecutive samples that disagree with the accepted value
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        samp_q <= 1'b0;
        run_q  <= '0;
        filt_o <= 1'b0;
        rise_o <= 1'b0;
        fall_o <= 1'b0;
      end else begin
        samp_q <= sync2_q;
        rise_o <= 1'b0;
        fall_o <= 1'b0;
        if (samp_q == filt_o) begin
          run_q <= '0;
        end else if (run_q == RUN_LAST) begin
          run_q  <= '0;
          filt_o <= samp_q;
          rise_o <= samp_q;
          fall_o <= ~samp_q;
        end else begin
          run_q <= run_q + RUN_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/hl_south_io_ctrl.sv
// rtl/hl_south_io_ctrl.sv - South IO bank controller: pad power sequencing, pad config and input return path
module hl_south_io_ctrl
  import hl_io_pkg::*;
#(
  parameter int N_SLICE       = 8,
  parameter int PWRUP_CYCLES  = 64,
  parameter int SETTLE_CYCLES = 16,
  parameter int FILT_CYCLES   = 4,
  parameter int SLICE_W       = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               pwr_en,
  output logic               io_ready,
  input  logic               cfg_wr_en,
  input  logic [SLICE_W-1:0] cfg_wr_slice,
  input  logic [CFG_W-1:0]   cfg_wr_data,
  input  logic [N_SLICE-1:0] core_out,
  input  logic [N_SLICE-1:0] core_oe,
  output logic [N_SLICE-1:0] core_in,
  output logic [N_SLICE-1:0] core_in_rise,
  output logic [N_SLICE-1:0] core_in_fall,
  output logic [N_SLICE-1:0] dq,
  output logic [N_SLICE-1:0] enq,
  output logic [N_SLICE-1:0] enabq,
  output logic [N_SLICE-1:0] drv0,
  output logic [N_SLICE-1:0] drv1,
  output logic [N_SLICE-1:0] drv2,
  output logic [N_SLICE-1:0] prg_slew,
  output logic [N_SLICE-1:0] ppen,
  output logic [N_SLICE-1:0] puq,
  output logic [N_SLICE-1:0] pd,
  output logic [N_SLICE-1:0] pwrup_pull_en,
  output logic [N_SLICE-1:0] pwrupzhl,
  input  logic [N_SLICE-1:0] outi
);

  localparam int CNT_MAX = (PWRUP_CYCLES > SETTLE_CYCLES) ? PWRUP_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PWRUP_LOAD  = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  io_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CFG_W-1:0] cfg_q [N_SLICE];

  logic [N_SLICE-1:0] ie_v, drv0_v, drv1_v, drv2_v, slew_v, ppen_v, puq_v, pd_v;
  logic               pads_hiz, pads_active;

  // Out-of-range slice numbers match no entry, so such writes are dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_SLICE; i++) cfg_q[i] <= '0;
    end else if (cfg_wr_en) begin
      for (int i = 0; i < N_SLICE; i++) begin
        if (cfg_wr_slice == SLICE_W'(i)) cfg_q[i] <= cfg_wr_data;
      end
    end
  end

  always_comb begin
    ie_v   = '0;
    drv0_v = '0;
    drv1_v = '0;
    drv2_v = '0;
    slew_v = '0;
    ppen_v = '0;
    puq_v  = '1;
    pd_v   = '0;
    for (int i = 0; i < N_SLICE; i++) begin
      drv0_v[i]           = cfg_q[i][CFG_DRV_LSB];
      drv1_v[i]           = cfg_q[i][CFG_DRV_LSB+1];
      drv2_v[i]           = cfg_q[i][CFG_DRV_LSB+2];
      slew_v[i]           = cfg_q[i][CFG_SLEW];
      ppen_v[i]           = cfg_q[i][CFG_PPEN];
      ie_v[i]             = cfg_q[i][CFG_IE];
      {puq_v[i], pd_v[i]} = pull_decode(cfg_q[i][CFG_PULL_LSB +: 2]);
    end
  end

  // Dropping pwr_en disables the pads on the same edge the FSM returns to HIZ.
  assign pads_hiz    = !pwr_en || (state_q == HIZ);
  assign pads_active = pwr_en && (state_q == ACTIVE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= HIZ;
      cnt_q         <= PWRUP_LOAD;
      io_ready      <= 1'b0;
      dq            <= '0;
      enq           <= '1;
      enabq         <= '1;
      drv0          <= '0;
      drv1          <= '0;
      drv2          <= '0;
      prg_slew      <= '0;
      ppen          <= '0;
      puq           <= '1;
      pd            <= '0;
      pwrup_pull_en <= '1;
      pwrupzhl      <= '1;
    end else begin
      if (!pwr_en) begin
        state_q <= HIZ;
        cnt_q   <= PWRUP_LOAD;
      end else begin
        case (state_q)
          HIZ: begin
            if (cnt_q == '0) begin
              state_q <= SETTLE;
              cnt_q   <= SETTLE_LOAD;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          SETTLE: begin
            if (cnt_q == '0) state_q <= ACTIVE;
            else             cnt_q   <= cnt_q - CNT_W'(1);
          end
          ACTIVE:  state_q <= ACTIVE;
          default: state_q <= HIZ;
        endcase
      end

      io_ready      <= pads_active;
      dq            <= pads_active ? core_out : '0;
      enq           <= pads_active ? ~core_oe : '1;
      enabq         <= pads_hiz ? '1 : ~ie_v;
      pwrup_pull_en <= pads_hiz ? '1 : '0;
      pwrupzhl      <= pads_hiz ? '1 : '0;
      drv0          <= drv0_v;
      drv1          <= drv1_v;
      drv2          <= drv2_v;
      prg_slew      <= slew_v;
      ppen          <= ppen_v;
      puq           <= puq_v;
      pd            <= pd_v;
    end
  end

  for (genvar g = 0; g < N_SLICE; g++) begin : g_slice
    hl_io_in_filter #(
      .FILT_CYCLES(FILT_CYCLES)
    ) u_filt (
      .clock  (clock),
      .reset_n(reset_n),
      .pad_i  (outi[g]),
      .filt_o (core_in[g]),
      .rise_o (core_in_rise[g]),
      .fall_o (core_in_fall[g])
    );
  end

endmodule
